// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch front end built around a DEPTH-entry prefetch FIFO. It
//   owns the fetch PC and drives the instruction memory address. Each fetched
//   instruction is queued together with its sequential next PC (PC+PC_STEP).
//   The oldest entry is offered to the ID stage through a valid/ready
//   handshake. A redirect flushes every queued entry and restarts fetch at
//   redirect_pc.
//
// Ports
//   clk          in   1        clock, rising edge
//   rst          in   1        asynchronous reset, active low
//   imem_addr    out  ADDR_W   fetch address (current fetch PC)
//   imem_rdata   in   DATA_W   instruction at imem_addr, same cycle
//   redirect     in   1        flush the queue and load redirect_pc
//   redirect_pc  in   ADDR_W   new fetch PC, used when redirect=1
//   id_ready     in   1        ID stage takes the head entry this cycle
//   id_valid     out  1        head entry valid
//   id_instr     out  DATA_W   head instruction (0 when id_valid=0)
//   id_pc_next   out  ADDR_W   head PC+PC_STEP (0 when id_valid=0)
//   count        out  CNT_W    occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  PC_RESET = '0,
  parameter int                 PC_STEP  = 4,
  localparam int                PTR_W    = $clog2(DEPTH),
  localparam int                CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc_next,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pcn_mem   [DEPTH];

  logic              deq;
  logic              enq;
  logic [ADDR_W-1:0] pc_inc;

  // Modulo 2^ADDR_W; wrap at the top of the address space is intentional.
  assign pc_inc = pc_q + ADDR_W'(PC_STEP);

  assign id_valid = (count_q != '0);
  assign deq      = id_valid & id_ready;
  // A full queue can still accept when the head leaves in the same cycle;
  // this is the only place id_ready reaches the write side.
  assign enq      = !redirect & ((count_q < CNT_W'(DEPTH)) | deq);

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (redirect) begin
      // Any same-cycle deq has already been taken by ID; the rest is dropped.
      pc_d     = redirect_pc;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_inc;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= PC_RESET;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pcn_mem[wr_ptr_q]   <= pc_inc;
    end
  end

  assign imem_addr  = pc_q;
  assign count      = count_q;
  assign id_instr   = id_valid ? instr_mem[rd_ptr_q] : '0;
  assign id_pc_next = id_valid ? pcn_mem[rd_ptr_q]   : '0;

endmodule
